// File: rtl/spi_master_byte.sv
// spi_master_byte: single-byte SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first.
// The sclk half-period is HALFPERIOD clk cycles, timed by a phase counter, so that
// responders behind synchronizers/debouncers still see clean, separated edges.
//
// Ports:
//   clk      system clock, all logic on posedge
//   reset    synchronous active-high reset
//   start    transfer request, sampled only while idle
//   tx_data  byte to send, latched on an accepted start
//   rx_data  last received byte, updated together with done
//   busy     high from the cycle after an accepted start until completion
//   done     one-clk completion pulse
//   sclk     SPI clock, idles low
//   cs       chip select, active low, idles high
//   mosi     serial data out
//   miso     serial data in (synchronous to clk)
module spi_master_byte #(
  parameter int HALFPERIOD   = 8,
  parameter int counterwidth = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] HIGH  = 3'd2;
  localparam logic [2:0] LOW   = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;
  localparam logic [2:0] GAP   = 3'd5;

  localparam logic [counterwidth-1:0] LAST = counterwidth'(HALFPERIOD - 1);

  logic [2:0]              state;
  logic [counterwidth-1:0] cnt;
  logic [2:0]              bitcnt;
  // Bit 7 goes straight from tx_data to mosi at start, so only the lower
  // seven bits need to be held for shifting.
  logic [6:0]              tx_sr;
  logic [7:0]              rx_sr;
  logic                    phase_end;

  assign phase_end = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bitcnt  <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
    end else if (state == IDLE) begin
      done <= 1'b0;
      cnt  <= '0;
      if (start) begin
        tx_sr  <= tx_data[6:0];
        cs     <= 1'b0;
        mosi   <= tx_data[7];
        busy   <= 1'b1;
        bitcnt <= '0;
        state  <= SETUP;
      end
    end else if (!phase_end) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
      case (state)
        SETUP: begin
          sclk  <= 1'b1;
          state <= HIGH;
        end
        HIGH: begin
          // Last cycle before the falling edge: latest safe point to sample miso.
          rx_sr <= {rx_sr[6:0], miso};
          sclk  <= 1'b0;
          if (bitcnt == 3'd7) begin
            state <= HOLD;
          end else begin
            bitcnt <= bitcnt + 1'b1;
            mosi   <= tx_sr[6];
            tx_sr  <= {tx_sr[5:0], 1'b0};
            state  <= LOW;
          end
        end
        LOW: begin
          sclk  <= 1'b1;
          state <= HIGH;
        end
        HOLD: begin
          cs    <= 1'b1;
          state <= GAP;
        end
        GAP: begin
          rx_data <= rx_sr;
          done    <= 1'b1;
          busy    <= 1'b0;
          mosi    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// Directed bench for spi_master_byte: one instance at HALFPERIOD=8 and one at
// HALFPERIOD=2, sharing clock, reset and tx_data; start is steered by sel2.
module tb_spi_master_byte;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       sel2 = 1'b0;
  logic       miso_tie = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic [7:0] rx8, rx2;
  logic       busy8, done8, sclk8, cs8, mosi8, miso8, start8;
  logic       busy2, done2, sclk2, cs2, mosi2, miso2, start2;

  // Observed view of the selected instance
  logic [7:0] v_rx;
  logic       v_busy, v_done, v_sclk, v_cs, v_mosi;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  assign start8 = start & ~sel2;
  assign start2 = start & sel2;
  assign miso8  = miso_tie ? 1'b1 : mosi8;
  assign miso2  = miso_tie ? 1'b1 : mosi2;

  assign v_rx   = sel2 ? rx2   : rx8;
  assign v_busy = sel2 ? busy2 : busy8;
  assign v_done = sel2 ? done2 : done8;
  assign v_sclk = sel2 ? sclk2 : sclk8;
  assign v_cs   = sel2 ? cs2   : cs8;
  assign v_mosi = sel2 ? mosi2 : mosi8;

  spi_master_byte #(.HALFPERIOD(8), .counterwidth(4)) u8 (
    .clk(clk), .reset(reset), .start(start8), .tx_data(tx_data),
    .rx_data(rx8), .busy(busy8), .done(done8), .sclk(sclk8),
    .cs(cs8), .mosi(mosi8), .miso(miso8)
  );

  spi_master_byte #(.HALFPERIOD(2), .counterwidth(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .tx_data(tx_data),
    .rx_data(rx2), .busy(busy2), .done(done2), .sclk(sclk2),
    .cs(cs2), .mosi(mosi2), .miso(miso2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Results of one transfer, sample index k counted from the edge where cs falls
  int         r_cs_low, r_pulses, r_hmin, r_hmax, r_lmin, r_lmax;
  int         r_done_n, r_done_k, r_busy_n, r_bad_mosi;
  logic [7:0] r_mosi, r_rx;
  logic       r_busy_at_done, r_mosi_any;

  // One start pulse, then observe 200 cycles at negedge (bounded, never waits on DUT).
  // At sample poke_at, start is pulsed again with tx_data=8'h3C.
  task automatic run_xfer(input logic [7:0] tx, input int poke_at);
    logic prev_s, prev_m;
    int   hrun, lrun;
    r_cs_low = 0; r_pulses = 0; r_hmin = 9999; r_hmax = 0; r_lmin = 9999; r_lmax = 0;
    r_done_n = 0; r_done_k = -1; r_busy_n = 0; r_bad_mosi = 0;
    r_mosi = '0; r_rx = '0; r_busy_at_done = 1'b1; r_mosi_any = 1'b0;
    @(negedge clk);
    tx_data = tx;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev_s = 1'b0; prev_m = v_mosi; hrun = 0; lrun = 0;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) @(negedge clk);
      if (!v_cs) r_cs_low++;
      if (v_busy) r_busy_n++;
      if (!v_cs) r_mosi_any = r_mosi_any | v_mosi;
      if (k > 0 && !v_cs && v_mosi != prev_m && !(prev_s && !v_sclk)) r_bad_mosi++;
      if (v_sclk && !prev_s) begin
        if (r_pulses > 0) begin
          if (lrun < r_lmin) r_lmin = lrun;
          if (lrun > r_lmax) r_lmax = lrun;
        end
        r_pulses++;
        r_mosi = {r_mosi[6:0], v_mosi};
        hrun = 0;
      end
      if (!v_sclk && prev_s) begin
        if (hrun < r_hmin) r_hmin = hrun;
        if (hrun > r_hmax) r_hmax = hrun;
        lrun = 0;
      end
      if (v_sclk) hrun++; else lrun++;
      prev_s = v_sclk;
      prev_m = v_mosi;
      if (v_done) begin
        r_done_n++;
        if (r_done_k < 0) begin
          r_done_k = k;
          r_rx = v_rx;
          r_busy_at_done = v_busy;
        end
      end
      if (k == poke_at) begin
        start = 1'b1;
        tx_data = 8'h3C;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    int         gap, done_seen, d1_k, d2_k, rose;
    logic [7:0] d1_rx, d2_rx, rx_before;

    repeat (3) @(negedge clk);
    check("rst_cs8", cs8, 1);
    check("rst_sclk8", sclk8, 0);
    check("rst_mosi8", mosi8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_rx8", rx8, 8'h00);
    check("rst_cs2", cs2, 1);
    check("rst_rx2", rx2, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // A5 loopback at H=8
    run_xfer(8'hA5, -1);
    check("a5_mosi_bits", r_mosi, 8'hA5);
    check("a5_pulses", r_pulses, 8);
    check("a5_high_min", r_hmin, 8);
    check("a5_high_max", r_hmax, 8);
    check("a5_low_min", r_lmin, 8);
    check("a5_low_max", r_lmax, 8);
    check("a5_cs_low", r_cs_low, 136);
    check("a5_busy_len", r_busy_n, 144);
    check("a5_done_at", r_done_k, 144);
    check("a5_done_cnt", r_done_n, 1);
    check("a5_rx", r_rx, 8'hA5);
    check("a5_mosi_edges", r_bad_mosi, 0);

    // miso tied high, tx 00
    miso_tie = 1'b1;
    run_xfer(8'h00, -1);
    miso_tie = 1'b0;
    check("ff_rx", r_rx, 8'hFF);
    check("ff_mosi_zero", r_mosi_any, 0);
    check("ff_busy_in_done", r_busy_at_done, 0);
    check("ff_done_at", r_done_k, 144);

    // start re-pulsed mid-transfer is ignored
    run_xfer(8'hA5, 40);
    check("ign_rx", r_rx, 8'hA5);
    check("ign_mosi_bits", r_mosi, 8'hA5);
    check("ign_done_cnt", r_done_n, 1);
    check("ign_pulses", r_pulses, 8);

    // reset at cycle 60 of a transfer
    @(negedge clk);
    tx_data = 8'h5A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 60; k++) @(negedge clk);
    check("rmid_in_xfer", cs8, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rmid_cs", cs8, 1);
    check("rmid_sclk", sclk8, 0);
    check("rmid_busy", busy8, 0);
    check("rmid_done", done8, 0);
    check("rmid_rx", rx8, 8'h00);
    reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done8) done_seen++;
    end
    check("rmid_no_done", done_seen, 0);
    run_xfer(8'h5A, -1);
    check("rmid_after_rx", r_rx, 8'h5A);
    check("rmid_after_done_at", r_done_k, 144);
    check("rmid_after_pulses", r_pulses, 8);

    // start held high: back-to-back 81 then 7E
    @(negedge clk);
    tx_data = 8'h81;
    start = 1'b1;
    @(negedge clk);
    tx_data = 8'h7E;
    gap = 0; rose = 0; done_seen = 0; d1_k = -1; d2_k = -1;
    d1_rx = '0; d2_rx = '0; rx_before = '0;
    for (int k = 0; k < 330; k++) begin
      if (k > 0) @(negedge clk);
      if (cs8 && k > 0 && k < 200) begin
        gap++;
        rose = 1;
      end
      if (rose == 1 && !cs8) begin
        rose = 2;
        start = 1'b0;
      end
      if (k == 288) rx_before = rx8;
      if (done8) begin
        done_seen++;
        if (d1_k < 0) begin
          d1_k = k; d1_rx = rx8;
        end else if (d2_k < 0) begin
          d2_k = k; d2_rx = rx8;
        end
      end
    end
    start = 1'b0;
    check("b2b_gap", gap, 9);
    check("b2b_done_cnt", done_seen, 2);
    check("b2b_done1_at", d1_k, 144);
    check("b2b_rx1", d1_rx, 8'h81);
    check("b2b_rx_hold", rx_before, 8'h81);
    check("b2b_done2_at", d2_k, 289);
    check("b2b_rx2", d2_rx, 8'h7E);

    // H=2 instance
    sel2 = 1'b1;
    run_xfer(8'hC3, -1);
    check("h2_pulses", r_pulses, 8);
    check("h2_high_min", r_hmin, 2);
    check("h2_high_max", r_hmax, 2);
    check("h2_low_min", r_lmin, 2);
    check("h2_low_max", r_lmax, 2);
    check("h2_cs_low", r_cs_low, 34);
    check("h2_done_at", r_done_k, 36);
    check("h2_mosi_bits", r_mosi, 8'hC3);
    check("h2_rx", r_rx, 8'hC3);
    sel2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/spi_master_byte.md
Name: spi_master_byte

Overview:
- Single-byte SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first.
- Drives sclk, cs and mosi toward an off-chip or on-board SPI responder and samples miso.
- sclk timing is generated from clk by a programmable half-period counter.
- Half-period is made long enough that a responder whose inputs pass through synchronizing and debouncing conditioners still sees clean, well-separated edges.

Parameters:
- HALFPERIOD, 8, clk cycles per sclk half-period. Legal range 2..2^counterwidth-1. For conditioned responders it must exceed the responder's conditioning latency.
- counterwidth, 4, phase-counter width in bits. Must be >= log2(HALFPERIOD+1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a transfer; sampled only in IDLE.
- tx_data  input  8  byte to send; latched on an accepted start.
- rx_data  output  8  last received byte; holds its value until the next completion.
- busy  output  1  high from the cycle after an accepted start until the transfer completes.
- done  output  1  one-clk pulse on completion.
- sclk  output  1  SPI clock; idles low.
- cs  output  1  chip select, active low; idles high.
- mosi  output  1  serial data out.
- miso  input  1  serial data in; treated as synchronous to clk (responder is clocked by sclk derived from clk).

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- Reset values: cs=1, sclk=0, mosi=0, busy=0, done=0, rx_data=8'h00. State=IDLE, counters=0.
- Reset wins over every other condition. Reset asserted mid-transfer gives reset values on the next edge, cs rising immediately, with no done pulse and no rx_data update.
- States: IDLE, SETUP, HIGH, LOW, HOLD, GAP. Every non-IDLE state lasts exactly HALFPERIOD cycles, timed by the phase counter running 0..HALFPERIOD-1. The counter clears on each state change.
- IDLE with start=1:
  - latch tx_data into the tx shift register;
  - set cs<=0, mosi<=tx_data[7], busy<=1, bitcount<=0;
  - go to SETUP.
- IDLE with start=0: no change; done<=0.
- SETUP end: sclk<=1, go to HIGH.
- HIGH, final cycle:
  - shift miso into the rx shift register LSB (sample at the latest point before the falling edge);
  - sclk<=0.
  - If bitcount=7, go to HOLD.
  - Otherwise bitcount++, mosi<=next tx bit (MSB first), go to LOW.
- LOW end: sclk<=1, go to HIGH.
- HOLD end (sclk low, mosi held): cs<=1, go to GAP.
- GAP end:
  - rx_data<=rx shift register;
  - done<=1 for exactly one cycle;
  - busy<=0;
  - mosi<=0;
  - go to IDLE.
- Timing with H=HALFPERIOD, counted from the edge where cs falls:
  - cs low for exactly 17*H cycles;
  - exactly 8 sclk high pulses, each H cycles;
  - first rising edge at H;
  - busy high 18*H cycles;
  - done and the rx_data update occur in the same cycle, the first cycle with busy=0.
- mosi changes only on the same edge as sclk falls, or on cs fall for bit 7. It is stable for the full H before each rising edge.
- start while busy=1 is ignored; tx_data changes while busy have no effect.
- start held high continuously: the next transfer is accepted in the done cycle. cs is therefore high for exactly H+1 cycles between back-to-back transfers.
- sclk never glitches: at most one transition per H cycles.

Test Plan:
- H=8, tx_data=8'hA5, miso looped from mosi, one start pulse:
  - mosi bit sequence 1,0,1,0,0,1,0,1;
  - 8 sclk pulses of 8 clk each;
  - cs low 136 cycles;
  - done one cycle at 144 cycles after cs fall;
  - rx_data=8'hA5.
- miso tied 1, tx_data=8'h00 -> rx_data=8'hFF, mosi=0 throughout, busy low in the done cycle.
- Pulse start again at cycle 40 of a transfer with tx_data=8'h3C -> ignored; the current byte completes unchanged and only one done pulse occurs.
- Assert reset at cycle 60 of a transfer -> next edge gives cs=1, sclk=0, busy=0, rx_data=8'h00, and no done pulse. A new start then runs a full, correct transfer.
- Hold start high with tx_data 8'h81 then 8'h7E, miso=mosi:
  - two transfers;
  - cs high gap 9 cycles;
  - rx_data=8'h81 then 8'h7E, each updating on its own done.
- HALFPERIOD=2 -> sclk pulses are 2 cycles high and 2 cycles low, with 8 pulses total and correct loopback data.
